ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter BUS_WIDTH, default 8: RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8: RAM data width.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles the block waits on ram_busy before aborting.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req0, req1  in  1  access request from requester 0 (core) and requester 1 (loader).
REQ-007 we0, we1  in  1  1 = write, 0 = read; qualified by reqN.
REQ-008 addr0, addr1  in  BUS_WIDTH  target address.
REQ-009 wdata0, wdata1  in  DATA_WIDTH  write data.
REQ-010 ack0, ack1  out  1  one-cycle completion pulse per requester.
REQ-011 rdata0, rdata1  out  DATA_WIDTH  read result, valid while ackN is high.
REQ-012 err  out  1  one-cycle pulse coincident with ack on timeout abort.
REQ-013 gnt_id  out  1  requester owning the current transaction.
REQ-014 ram_rd_en, ram_wr_en  out  1  RAM read/write strobes.
REQ-015 ram_addr_rd, ram_addr_wr  out  BUS_WIDTH  RAM addresses.
REQ-016 ram_dwrite  out  DATA_WIDTH  RAM write data.
REQ-017 ram_dout  in  DATA_WIDTH  RAM read data.
REQ-018 ram_busy  in  1  RAM operation in progress.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; all outputs SHALL be registered.
REQ-020 In IDLE with any reqN high, the block SHALL latch we, addr and wdata of the selected requester, set gnt_id, and go to ISSUE.
REQ-021 With both requests high in IDLE, the block SHALL select the requester not served last (round-robin); last-served SHALL reset to 1, so requester 0 wins first.
REQ-022 In ISSUE, the block SHALL assert exactly one of ram_rd_en or ram_wr_en for exactly one cycle, drive ram_addr_rd or ram_addr_wr and ram_dwrite from the latched values, and go to WAIT.
REQ-023 In WAIT, the block SHALL go to DONE on the first cycle ram_busy is low, capturing ram_dout for reads; ram_busy SHALL be ignored in ISSUE.
REQ-024 A WAIT cycle counter SHALL increment while ram_busy is high; when it reaches TIMEOUT, the block SHALL go to DONE with err set and captured data forced to 0.
REQ-025 In DONE, the block SHALL pulse ack of gnt_id for one cycle with rdata (0 for writes), update last-served, and return to IDLE; no arbitration SHALL occur in DONE.
REQ-026 Minimum latency SHALL be 3 cycles from a req sampled in IDLE to ack; maximum throughput SHALL be one transaction per 4 cycles.
REQ-027 Changes to we, addr or wdata after the grant SHALL be ignored; deasserting req after the grant SHALL NOT cancel the transaction, and ack SHALL still pulse.
REQ-028 A requester holding req high through its ack SHALL be treated as a new request in the following IDLE.
REQ-029 rdata of the non-granted requester SHALL be 0; ack0 and ack1 SHALL never be high together.

Reset
REQ-030 With rst high at a clock edge, the block SHALL enter IDLE, clear all outputs, the counter, gnt_id and latched data to 0, and set last-served to 1.
REQ-031 Reset mid-transaction SHALL discard it with no ack or err pulse; RAM strobes SHALL be low in the cycle after reset.

Verification
REQ-032 Single read: req0=1, we0=0, addr0=0x12, RAM returns 0xA5 with busy low -> ram_rd_en pulses at cycle 1, ack0 and rdata0=0xA5 at cycle 3.
REQ-033 Single write: req1=1, we1=1, addr1=0x30, wdata1=0x5C -> ram_wr_en=1, ram_addr_wr=0x30, ram_dwrite=0x5C for one cycle; ack1 with rdata1=0.
REQ-034 Contention: req0 and req1 held high from reset for 4 transactions -> grant order 0,1,0,1, acks every 4 cycles.
REQ-035 Timeout: ram_busy stuck high -> ack and err pulse together after TIMEOUT (16) WAIT cycles, rdata=0, FSM back in IDLE.
REQ-036 Slow RAM: busy high for 5 cycles -> ack 8 cycles after the req is sampled, no err.
REQ-037 Reset in WAIT: rst asserted for one cycle -> no ack, all outputs 0, next req0 is served normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a single-port RAM with busy handshake and timeout abort
module ram_arbiter #(
    parameter int BUS_WIDTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [BUS_WIDTH-1:0]  addr0,
    input  logic [BUS_WIDTH-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err,
    output logic                  gnt_id,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    output logic [BUS_WIDTH-1:0]  ram_addr_rd,
    output logic [BUS_WIDTH-1:0]  ram_addr_wr,
    output logic [DATA_WIDTH-1:0] ram_dwrite,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic                  last;
    logic                  we_q;
    logic                  err_q;
    logic [BUS_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]         cnt;
    logic                  sel;

    // contention goes to whoever was not served last, otherwise to the lone requester
    assign sel = (req0 && req1) ? ~last : req1;

    // transaction FSM; every output is a register written here
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            cnt         <= '0;
            gnt_id      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err         <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            ram_rd_en   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_addr_rd <= '0;
            ram_addr_wr <= '0;
            ram_dwrite  <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            ram_rd_en <= 1'b0;
            ram_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_id  <= sel;
                        we_q    <= sel ? we1 : we0;
                        addr_q  <= sel ? addr1 : addr0;
                        wdata_q <= sel ? wdata1 : wdata0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_rd_en <= ~we_q;
                    ram_wr_en <= we_q;
                    if (we_q) begin
                        ram_addr_wr <= addr_q;
                        ram_dwrite  <= wdata_q;
                    end else begin
                        ram_addr_rd <= addr_q;
                    end
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!ram_busy) begin
                        data_q <= we_q ? '0 : ram_dout;
                        err_q  <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + ONE;
                        if (cnt == TMAX - ONE) begin
                            data_q <= '0;
                            err_q  <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    ack0   <= ~gnt_id;
                    ack1   <= gnt_id;
                    rdata0 <= gnt_id ? '0 : data_q;
                    rdata1 <= gnt_id ? data_q : '0;
                    err    <= err_q;
                    last   <= gnt_id;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table, directed corner sequences and random traffic against a transaction-level model
module tb_ram_arbiter;
    localparam int BW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [BW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err, gnt_id, ram_rd_en, ram_wr_en, ram_busy;
    logic [DW-1:0] rdata0, rdata1, ram_dwrite, ram_dout;
    logic [BW-1:0] ram_addr_rd, ram_addr_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err(err), .gnt_id(gnt_id),
        .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_addr_rd(ram_addr_rd), .ram_addr_wr(ram_addr_wr),
        .ram_dwrite(ram_dwrite), .ram_dout(ram_dout), .ram_busy(ram_busy)
    );

    // bench RAM: contents reset to addr^0xB7, busy held for busy_len cycles starting with the strobe
    logic [7:0] mem [256];
    logic [7:0] bcnt = 8'd0;
    int         busy_len = 0;
    assign ram_busy = (ram_rd_en || ram_wr_en) ? (busy_len > 0) : (bcnt != 8'd0);
    assign ram_dout = mem[ram_addr_rd];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB7;
        end else if (ram_wr_en) begin
            mem[ram_addr_wr] <= ram_dwrite;
        end
        if (ram_rd_en || ram_wr_en) bcnt <= (busy_len > 0) ? 8'(busy_len - 1) : 8'd0;
        else if (bcnt != 8'd0) bcnt <= bcnt - 8'd1;
    end

    // transaction-level reference model
    logic [7:0] ref_mem [256];
    int         cyc = 0;
    int         plan_len = 0;
    bit         m_last = 1'b1;
    int         next_idle = 0;
    bit         pend = 1'b0;
    bit         was_rst = 1'b0;
    int         gnt_e, ack_e;
    bit         e_id, e_we, e_err;
    logic [7:0] e_addr, e_wdata, e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        was_rst = rst;
        if (rst) begin
            m_last = 1'b1;
            pend = 1'b0;
            next_idle = cyc + 1;
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB7;
        end else if (cyc >= next_idle && (req0 || req1)) begin
            e_id    = (req0 && req1) ? ~m_last : req1;
            e_we    = e_id ? we1 : we0;
            e_addr  = e_id ? addr1 : addr0;
            e_wdata = e_id ? wdata1 : wdata0;
            e_err   = plan_len >= TO;
            busy_len = plan_len;
            gnt_e = cyc;
            ack_e = e_err ? cyc + 2 + TO : cyc + 3 + plan_len;
            e_data = (e_we || e_err) ? 8'h00 : ref_mem[e_addr];
            if (e_we) ref_mem[e_addr] = e_wdata;
            m_last = e_id;
            next_idle = ack_e + 1;
            pend = 1'b1;
        end
    endtask

    task automatic check_edge();
        bit at_ack, strobe;
        at_ack = pend && cyc == ack_e;
        strobe = pend && cyc == gnt_e + 1;
        chk("ack0", ack0, at_ack && !e_id);
        chk("ack1", ack1, at_ack && e_id);
        chk("err", err, at_ack && e_err);
        chk("rdata0", rdata0, (at_ack && !e_id) ? e_data : 8'h00);
        chk("rdata1", rdata1, (at_ack && e_id) ? e_data : 8'h00);
        chk("rd_en", ram_rd_en, strobe && !e_we);
        chk("wr_en", ram_wr_en, strobe && e_we);
        if (strobe && e_we) begin
            chk("addr_wr", ram_addr_wr, e_addr);
            chk("dwrite", ram_dwrite, e_wdata);
        end
        if (strobe && !e_we) chk("addr_rd", ram_addr_rd, e_addr);
        if (at_ack) begin
            chk("gnt_id", gnt_id, e_id);
            pend = 1'b0;
        end
        if (was_rst) chk("gnt_rst", gnt_id, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_edge();
        @(negedge clk);
    endtask

    typedef struct {
        bit r0; bit w0; logic [7:0] a0; logic [7:0] d0;
        bit r1; bit w1; logic [7:0] a1; logic [7:0] d1;
        int len; bit x_id; logic [7:0] x_data; bit x_err; int x_lat;
    } vec_t;

    task automatic run_vec(input string name, input vec_t v);
        bit got;
        int lat;
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        plan_len = v.len;
        tick();
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = 8'($urandom); addr1 = 8'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        got = 1'b0;
        lat = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            lat++;
            if (ack0 || ack1) begin
                got = 1'b1;
                chk({name, "_lat"}, lat, v.x_lat);
                chk({name, "_id"}, gnt_id, v.x_id);
                chk({name, "_rdata"}, ack1 ? rdata1 : rdata0, v.x_data);
                chk({name, "_err"}, err, v.x_err);
            end
        end
        if (!got) chk({name, "_ack_seen"}, 0, 1);
    endtask

    vec_t vecs [7];

    initial begin
        bit got;
        int na;
        int ids [4];
        int ts [4];
        vecs[0] = '{1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00, 0,   0, 8'hA5, 0, 3};
        vecs[1] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h5C, 0,   1, 8'h00, 0, 3};
        vecs[2] = '{1, 0, 8'h30, 8'h00, 1, 0, 8'h12, 8'h00, 0,   0, 8'h5C, 0, 3};
        vecs[3] = '{1, 1, 8'h40, 8'h11, 1, 0, 8'h30, 8'h00, 5,   1, 8'h5C, 0, 8};
        vecs[4] = '{1, 0, 8'h55, 8'h00, 0, 0, 8'h00, 8'h00, 255, 0, 8'h00, 1, 18};
        vecs[5] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 15,  1, 8'hF7, 0, 18};
        vecs[6] = '{1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 16,  0, 8'h00, 1, 18};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_ack0", ack0, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // both requesters held from reset: alternate grants, one ack every 4 cycles
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 8'h01; addr1 = 8'h02;
        plan_len = 0;
        tick();
        rst = 1'b0;
        na = 0;
        for (int n = 0; n < 40 && na < 4; n++) begin
            tick();
            if (ack0 || ack1) begin
                ids[na] = ack1 ? 1 : 0;
                ts[na] = cyc;
                na++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("cont_count", na, 4);
        for (int i = 0; i < na; i++) begin
            chk($sformatf("cont_id%0d", i), ids[i], i % 2);
            if (i > 0) chk($sformatf("cont_gap%0d", i), ts[i] - ts[i-1], 4);
        end
        for (int n = 0; n < 8; n++) tick();

        // reset while waiting on a stuck RAM: transaction vanishes, next read is clean
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h12; plan_len = 255;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_gnt", gnt_id, 0);
        chk("rstw_err", err, 0);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (ack0 || ack1 || err) got = 1'b1;
        end
        chk("rstw_no_ack", got, 0);
        run_vec("after_rst", '{1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'hA5, 0, 3});

        // random traffic, fields changing every cycle
        for (int n = 0; n < 600; n++) begin
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = 8'($urandom_range(0, 15)); addr1 = 8'($urandom_range(0, 15));
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            plan_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 0;
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int n = 0; n < 40; n++) tick();
        if (pend) chk("drain_pending", 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
